// File: rtl/fp32_divider_seq.sv
// fp32_divider_seq: iterative binary32 divider, one quotient bit per cycle.
// Ports: clk, reset (sync, active-high), start/A/B/round_mode in;
//        busy, done, resultDiv, errorDiv, overflowDiv out.
module fp32_divider_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  round_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] resultDiv,
    output logic        errorDiv,
    output logic        overflowDiv
);

    typedef enum logic [2:0] {
        IDLE, SPECIAL, DIVIDE, ROUND, DONE
    } state_t;

    state_t state, state_nx;

    logic              sign_r;
    logic [1:0]        rm_r;
    logic [23:0]       m2_r;
    logic [24:0]       rem_r;
    logic [25:0]       q_r;
    logic [4:0]        cnt_r;
    logic signed [9:0] exp_r;
    logic [31:0]       sp_res_r;
    logic              sp_err_r;

    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic is_special, accept, sign_in;
    logic [31:0] sp_res;
    logic        sp_err;

    assign a_zero  = (A[30:23] == 8'h00);
    assign b_zero  = (B[30:23] == 8'h00);
    assign a_inf   = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    assign b_inf   = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    assign a_nan   = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    assign b_nan   = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    assign sign_in = A[31] ^ B[31];

    // Any zero, inf or NaN operand resolves without dividing.
    assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    assign accept     = start && (state == IDLE || state == DONE);

    // Special-case result, first match wins.
    always_comb begin
        sp_res = {sign_in, 31'd0};
        sp_err = 1'b0;
        if (a_nan || b_nan) begin
            sp_res = 32'h7FC0_0000;
            sp_err = 1'b1;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_res = 32'h7FC0_0000;
            sp_err = 1'b1;
        end else if (a_inf) begin
            sp_res = {sign_in, 8'hFF, 23'd0};
        end else if (b_zero) begin
            sp_res = {sign_in, 8'hFF, 23'd0};
            sp_err = 1'b1;
        end
    end

    // Restoring step: subtract divisor when it fits.
    logic        ge;
    logic [24:0] rem_nx;

    assign ge     = (rem_r >= {1'b0, m2_r});
    assign rem_nx = ge ? (rem_r - {1'b0, m2_r}) : rem_r;

    // Normalise, round and range-check the finished quotient.
    logic              norm, guard, sticky, inc;
    logic [23:0]       mant, mant_r;
    logic [24:0]       sum;
    logic signed [9:0] e_n, e_r;
    logic [31:0]       rnd_res;
    logic              rnd_err, rnd_ovf;

    always_comb begin
        norm   = q_r[25];
        mant   = norm ? q_r[25:2] : q_r[24:1];
        guard  = norm ? q_r[1] : q_r[0];
        sticky = (norm & q_r[0]) | (rem_r != 25'd0);
        e_n    = norm ? exp_r : exp_r - 10'sd1;
        inc    = 1'b0;
        unique case (rm_r)
            2'b10:   inc = guard & (sticky | mant[0]);
            2'b11:   inc = 1'b0;
            2'b00:   inc = (guard | sticky) & ~sign_r;
            default: inc = (guard | sticky) & sign_r;
        endcase
        sum    = {1'b0, mant} + {24'd0, inc};
        mant_r = sum[23:0];
        e_r    = e_n;
        if (sum[24]) begin
            mant_r = sum[24:1];
            e_r    = e_n + 10'sd1;
        end
        rnd_res = {sign_r, e_r[7:0], mant_r[22:0]};
        rnd_err = 1'b0;
        rnd_ovf = 1'b0;
        if (e_r >= 10'sd255) begin
            rnd_res = {sign_r, 8'hFF, 23'd0};
            rnd_err = 1'b1;
            rnd_ovf = 1'b1;
        end else if (e_r <= 10'sd0) begin
            rnd_res = {sign_r, 31'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start) state_nx = is_special ? SPECIAL : DIVIDE;
            end
            SPECIAL: state_nx = DONE;
            DIVIDE:  if (cnt_r == 5'd25) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == DIVIDE) || (state == ROUND);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_r      <= 1'b0;
            rm_r        <= 2'b00;
            m2_r        <= 24'd0;
            rem_r       <= 25'd0;
            q_r         <= 26'd0;
            cnt_r       <= 5'd0;
            exp_r       <= 10'sd0;
            sp_res_r    <= 32'd0;
            sp_err_r    <= 1'b0;
            resultDiv   <= 32'd0;
            errorDiv    <= 1'b0;
            overflowDiv <= 1'b0;
        end else begin
            if (accept) begin
                sign_r   <= sign_in;
                rm_r     <= round_mode;
                m2_r     <= {1'b1, B[22:0]};
                rem_r    <= {2'b01, A[22:0]};
                q_r      <= 26'd0;
                cnt_r    <= 5'd0;
                exp_r    <= $signed({2'b00, A[30:23]} - {2'b00, B[30:23]} + 10'd127);
                sp_res_r <= sp_res;
                sp_err_r <= sp_err;
            end
            if (state == DIVIDE) begin
                q_r   <= {q_r[24:0], ge};
                rem_r <= {rem_nx[23:0], 1'b0};
                cnt_r <= cnt_r + 5'd1;
            end
            if (state == SPECIAL) begin
                resultDiv   <= sp_res_r;
                errorDiv    <= sp_err_r;
                overflowDiv <= 1'b0;
            end
            if (state == ROUND) begin
                resultDiv   <= rnd_res;
                errorDiv    <= rnd_err;
                overflowDiv <= rnd_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fp32_divider_seq.sv
// tb_fp32_divider_seq: scoreboard bench for fp32_divider_seq.
// Directed spec vectors plus random operands against an integer model.
module tb_fp32_divider_seq;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] A, B;
    logic [1:0]  round_mode;
    logic        busy, done;
    logic [31:0] resultDiv;
    logic        errorDiv, overflowDiv;

    fp32_divider_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .A(A), .B(B), .round_mode(round_mode),
        .busy(busy), .done(done), .resultDiv(resultDiv),
        .errorDiv(errorDiv), .overflowDiv(overflowDiv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic        ovf;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_lo = 1;
    int busy_hi = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Reference: exact integer quotient, then IEEE-style rounding.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] rm);
        bit s;
        int ea, eb, e;
        logic [22:0] fa, fb;
        bit az, bz, ai, bi, an, bn, g, st, up;
        longint unsigned num, den, qq, rr, mant;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        if (an || bn) return {2'b01, 32'h7FC00000};
        if ((az && bz) || (ai && bi)) return {2'b01, 32'h7FC00000};
        if (ai) return {2'b00, s, 8'hFF, 23'h0};
        if (bz) return {2'b01, s, 8'hFF, 23'h0};
        if (az || bi) return {2'b00, s, 31'h0};
        num = longint'({1'b1, fa}) << 40;
        den = longint'({1'b1, fb});
        qq  = num / den;
        rr  = num % den;
        e   = ea - eb + 127;
        if (qq >= (64'd1 << 40)) begin
            mant = qq >> 17;
            g    = qq[16];
            st   = ((qq & 64'hFFFF) != 0) || (rr != 0);
        end else begin
            mant = qq >> 16;
            g    = qq[15];
            st   = ((qq & 64'h7FFF) != 0) || (rr != 0);
            e    = e - 1;
        end
        case (rm)
            2'b10:   up = g && (st || mant[0]);
            2'b11:   up = 1'b0;
            2'b00:   up = (g || st) && !s;
            default: up = (g || st) && s;
        endcase
        mant = mant + longint'(up);
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) return {2'b11, s, 8'hFF, 23'h0};
        if (e <= 0) return {2'b00, s, 31'h0};
        return {2'b00, s, e[7:0], mant[22:0]};
    endfunction

    function automatic bit is_spec(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] rnd_fp();
        int sel;
        logic [7:0] ex;
        logic [22:0] fr;
        sel = $urandom_range(0, 19);
        fr  = 23'($urandom);
        if (sel == 0) ex = 8'h00;
        else if (sel == 1) begin
            ex = 8'hFF;
            if ($urandom_range(0, 1) == 0) fr = 23'd0;
        end
        else if (sel <= 3) ex = 8'($urandom_range(1, 4));
        else if (sel <= 5) ex = 8'($urandom_range(250, 254));
        else ex = 8'($urandom_range(1, 254));
        return {1'($urandom), ex, fr};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: busy window every cycle, result popped on each done.
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        checks++;
        if (busy !== exp_busy) begin
            failures++;
            $display("FAIL busy cyc=%0d actual=%b required=%b", cyc, busy, exp_busy);
        end
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done cyc=%0d actual=1 required=0", cyc);
            end else begin
                e = sbq.pop_front();
                checks++;
                if ({overflowDiv, errorDiv, resultDiv} !== {e.ovf, e.err, e.res}) begin
                    failures++;
                    $display("FAIL %s result actual=%h e=%b o=%b required=%h e=%b o=%b",
                             e.name, resultDiv, errorDiv, overflowDiv, e.res, e.err, e.ovf);
                end
                checks++;
                if (cyc != e.acc + e.lat) begin
                    failures++;
                    $display("FAIL %s latency actual=%0d required=%0d",
                             e.name, cyc - e.acc, e.lat);
                end
            end
        end
    end

    // Call at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                         input bit use_exp, input logic [33:0] expv, input string nm);
        exp_t e;
        logic [33:0] m;
        bit sp;
        m  = use_exp ? expv : model(a, b, rm);
        sp = is_spec(a, b);
        A = a;
        B = b;
        round_mode = rm;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.res  = m[31:0];
        e.err  = m[32];
        e.ovf  = m[33];
        e.acc  = cyc;
        e.lat  = sp ? 1 : 27;
        e.name = nm;
        sbq.push_back(e);
        if (!sp) begin
            busy_lo = cyc;
            busy_hi = cyc + 26;
        end
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        round_mode = 2'($urandom);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        checks++;
        failures++;
        $display("FAIL %s timeout actual=no_done required=done", nm);
    endtask

    task automatic dir(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       input logic [31:0] res, input logic err, input logic ovf,
                       input string nm);
        issue(a, b, rm, 1'b1, {ovf, err, res}, nm);
        wait_done(nm);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        round_mode = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_state", {27'd0, busy, done, errorDiv, overflowDiv, resultDiv}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        dir(32'h40C00000, 32'h40000000, 2'b10, 32'h40400000, 0, 0, "div6_2");
        dir(32'h3F800000, 32'h40400000, 2'b10, 32'h3EAAAAAB, 0, 0, "third_rne");
        dir(32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAA, 0, 0, "third_rz");
        dir(32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 0, 0, "third_pinf");
        dir(32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, 0, 0, "third_ninf");
        dir(32'hBF800000, 32'h40400000, 2'b01, 32'hBEAAAAAB, 0, 0, "mthird_ninf");
        dir(32'h3F800000, 32'h00000000, 2'b10, 32'h7F800000, 1, 0, "div_by_zero");
        dir(32'h00000000, 32'h00000000, 2'b10, 32'h7FC00000, 1, 0, "zero_zero");
        dir(32'h7FC00000, 32'h3F800000, 2'b10, 32'h7FC00000, 1, 0, "nan_in");
        dir(32'h3F800000, 32'h7F800000, 2'b10, 32'h00000000, 0, 0, "fin_inf");
        dir(32'h7F000000, 32'h3E800000, 2'b10, 32'h7F800000, 1, 1, "overflow");
        dir(32'h00800000, 32'h40000000, 2'b10, 32'h00000000, 0, 0, "underflow");

        // Start pulsed mid-divide must be ignored.
        issue(32'h40C00000, 32'h40000000, 2'b10, 1'b1, {2'b00, 32'h40400000}, "ignored_start");
        repeat (5) @(negedge clk);
        A = 32'h3F800000;
        B = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start");
        // Back-to-back: issued during the done cycle.
        dir(32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAA, 0, 0, "back_to_back");

        // Reset in the middle of a divide.
        repeat (2) @(negedge clk);
        issue(32'h3F800000, 32'h40400000, 2'b10, 1'b1, {2'b00, 32'h3EAAAAAB}, "aborted");
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sbq.delete();
        busy_lo = 1;
        busy_hi = 0;
        @(negedge clk);
        chk("abort_outputs", {27'd0, busy, done, errorDiv, overflowDiv, resultDiv}, 64'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        dir(32'h40C00000, 32'h40000000, 2'b10, 32'h40400000, 0, 0, "after_reset");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            ra = rnd_fp();
            rb = rnd_fp();
            issue(ra, rb, 2'($urandom), 1'b0, 34'd0, "random");
            wait_done("random");
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
